// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// -----------------
// Multi-cycle shift-and-add multiplier controller. It produces the low 32 bits
// of an unsigned 32x32 product, with MIPS `mul` semantics. The shared 32-bit
// ALU is its only arithmetic resource. Each multiplier bit takes three ALU
// passes:
//   ADD : prod + mcand   (the result is kept only when mplier[0] is set)
//   SHL : mcand << 1
//   SHR : mplier >> 1    (also counts the iteration)
// The block drives the ALU operands and control only while it is busy. In IDLE
// and DONE it drives zeros.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               request pulse; only sampled in IDLE
//   a, b                multiplicand and multiplier, captured on accepted start
//   busy                high from the cycle after start through the DONE cycle
//   done                one-cycle pulse; product is valid
//   product             low 32 bits of a*b; held until the next accepted start
//   alu_a, alu_b        ALU operands
//   alu_ctrl            ALU control (0010 add, 0101 b<<1, 0111 b>>1)
//   alu_result          combinational ALU result for the current operands
//
// Parameter
//   EARLY_EXIT          when non-zero, stop once the shifted multiplier is zero;
//                       otherwise always run 32 iterations
module alu_mul_sequencer #(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result
);

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_SHR = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic [5:0]  count_q, count_d;

  // Zero detect on the shifted multiplier is done here, on alu_result itself.
  // No ALU zero flag is used.
  logic result_zero;
  assign result_zero = (alu_result == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      prod_q   <= 32'd0;
      count_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctrl = ALU_NOP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          prod_d   = 32'd0;
          count_d  = 6'd0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        alu_a    = prod_q;
        alu_b    = mcand_q;
        alu_ctrl = ALU_ADD;
        if (mplier_q[0]) begin
          prod_d = alu_result;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_b    = mcand_q;
        alu_ctrl = ALU_SHL;
        mcand_d  = alu_result;
        state_d  = S_SHR;
      end
      S_SHR: begin
        alu_b    = mplier_q;
        alu_ctrl = ALU_SHR;
        mplier_d = alu_result;
        count_d  = count_q + 6'd1;
        // A count of 31 here means this is the 32nd iteration.
        if ((count_q == 6'd31) || ((EARLY_EXIT != 0) && result_zero)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_ne = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        busy, done, busy_ne, done_ne;
  logic [31:0] product, product_ne;
  logic [31:0] alu_a, alu_b, alu_result, alu_a_ne, alu_b_ne, alu_result_ne;
  logic [3:0]  alu_ctrl, alu_ctrl_ne;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Reference ALU for the codes that the sequencer may use.
  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] c);
    case (c)
      4'b0010: alu_f = x + y;
      4'b0101: alu_f = y << 1;
      4'b0111: alu_f = y >> 1;
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_result_ne = alu_f(alu_a_ne, alu_b_ne, alu_ctrl_ne);

  alu_mul_sequencer #(.EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  alu_mul_sequencer #(.EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .start(start_ne), .a(a), .b(b),
    .busy(busy_ne), .done(done_ne), .product(product_ne),
    .alu_a(alu_a_ne), .alu_b(alu_b_ne), .alu_ctrl(alu_ctrl_ne), .alu_result(alu_result_ne)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of iterations: the bit length of b (at least 1), or always 32.
  function automatic int iters(input logic [31:0] bv, input bit ee);
    logic [31:0] x;
    int n;
    if (!ee) return 32;
    n = 1;
    x = bv >> 1;
    while (x != 32'd0) begin
      n++;
      x = x >> 1;
    end
    return n;
  endfunction

  // ---------------- behavioural model of the EARLY_EXIT=1 instance ----------
  // The model does not track any machine state. It counts the cycles since the
  // accepted start and derives from the operands what the outputs must be.
  logic        m_busy;
  int          m_cnt, m_n;
  logic [31:0] m_a, m_b, m_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_n <= 1;
      m_a <= 32'd0; m_b <= 32'd0; m_prod <= 32'd0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_cnt <= 1; m_a <= a; m_b <= b; m_n <= iters(b, 1'b1);
      end
    end else if (m_cnt == 3 * m_n + 1) begin
      m_busy <= 1'b0;
      m_prod <= m_a * m_b;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Compares the DUT outputs with the model on every cycle.
  always @(negedge clk) begin
    logic        e_done;
    logic [3:0]  e_ctrl;
    logic [31:0] e_a, e_b, e_prod;
    logic [63:0] mask;
    int k, ph;
    e_done = m_busy && (m_cnt == 3 * m_n + 1);
    e_ctrl = 4'b0000; e_a = 32'd0; e_b = 32'd0;
    if (m_busy && !e_done) begin
      k  = (m_cnt - 1) / 3;
      ph = (m_cnt - 1) % 3;
      mask = (64'd1 << k) - 64'd1;
      if (ph == 0) begin
        e_ctrl = 4'b0010;
        e_a = 32'(64'(m_a) * (64'(m_b) & mask));
        e_b = m_a << k;
      end else if (ph == 1) begin
        e_ctrl = 4'b0101;
        e_b = m_a << k;
      end else begin
        e_ctrl = 4'b0111;
        e_b = m_b >> k;
      end
    end
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, e_done});
    check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e_ctrl});
    check("alu_a", alu_a, e_a);
    check("alu_b", alu_b, e_b);
    if (!m_busy || e_done) begin
      e_prod = e_done ? (m_a * m_b) : m_prod;
      check("product", product, e_prod);
    end
  end

  // ---------------- stimulus -------------------------------------------------
  // launch: present the operands. The next rising edge is the accepting edge
  // (edge 0). The task returns just after that edge, which is in cycle 1.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input bit ne);
    @(posedge clk); #1;
    a = av; b = bv;
    if (ne) start_ne = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_ne = 1'b0;
  endtask

  // Waits for done (bounded). The caller is in cycle `from`. Returns the cycle
  // number where done is seen, or 999 when the budget runs out.
  task automatic wait_done(input int from, input bit ne, output int cyc);
    cyc = from;
    while (!(ne ? done_ne : done)) begin
      if (cyc >= 200) begin
        cyc = 999;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, pulses;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset product", product, 32'd0);
    check("reset alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    #5 rst_n = 1'b1;

    launch(32'd3, 32'd5, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 3*5: done cycle %0d product 0x%08h", cyc, product);
    check("3x5 cycle", cyc, 32'd10);
    check("3x5 product", product, 32'd15);

    launch(32'h00010000, 32'h00010000, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 0x10000^2: done cycle %0d product 0x%08h", cyc, product);
    check("ovf cycle", cyc, 32'd52);
    check("ovf product", product, 32'd0);

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op ffff^2: done cycle %0d product 0x%08h", cyc, product);
    check("max cycle", cyc, 32'd97);
    check("max product", product, 32'd1);

    launch(32'd7, 32'd0, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 7*0 early: done cycle %0d product 0x%08h", cyc, product);
    check("b0 cycle", cyc, 32'd4);
    check("b0 product", product, 32'd0);

    launch(32'd7, 32'd0, 1'b1);
    wait_done(1, 1'b1, cyc);
    $display("op 7*0 no-early: done cycle %0d product 0x%08h", cyc, product_ne);
    check("b0 ne cycle", cyc, 32'd97);
    check("b0 ne product", product_ne, 32'd0);

    // a=0: iterations still run for the bit length of b.
    launch(32'd0, 32'd12, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 0*12: done cycle %0d product 0x%08h", cyc, product);
    check("a0 cycle", cyc, 32'd13);
    check("a0 product", product, 32'd0);

    // A second start while busy is ignored. Then restart right after done.
    launch(32'd6, 32'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, 1'b0, cyc);
    $display("op 6*7 with ignored start: done cycle %0d product 0x%08h", cyc, product);
    check("ignored cycle", cyc, 32'd10);
    check("ignored product", product, 32'd42);
    launch(32'd2, 32'd2, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 2*2 back-to-back: done cycle %0d product 0x%08h", cyc, product);
    check("b2b cycle", cyc, 32'd7);
    check("b2b product", product, 32'd4);

    // start held high: one op every 8 cycles (7 busy + 1 idle).
    @(posedge clk); #1;
    a = 32'd2; b = 32'd2; start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 16) start = 1'b0;
      if (done) pulses++;
    end
    $display("held start: %0d done pulses in 16 cycles", pulses);
    check("held pulses", pulses, 32'd2);

    // Reset mid-operation.
    launch(32'd9, 32'd9, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: busy %0b done %0b product 0x%08h", busy, done, product);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort product", product, 32'd0);
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
    check("abort no done", pulses, 32'd0);
    rst_n = 1'b1;
    launch(32'd2, 32'd3, 1'b0);
    wait_done(1, 1'b0, cyc);
    $display("op 2*3 after reset: done cycle %0d product 0x%08h", cyc, product);
    check("post-reset product", product, 32'd6);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low 32 bits of an unsigned 32x32 product (MIPS `mul` semantics).
- Uses the shared 32-bit ALU as its only arithmetic resource, time-multiplexing ADD, shift-left-1 and shift-right-1 operations.
- Sits between the decode/execute control and the ALU operand muxes.
- Owns ALU operand/control selection only while busy.

Parameters:
- EARLY_EXIT, 1, when 1 terminate as soon as the shifted multiplier is zero; when 0 always run 32 iterations.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled in IDLE only.
- a  input  32  multiplicand, captured on accepted start.
- b  input  32  multiplier, captured on accepted start.
- busy  output  1  high from the cycle after start through the DONE cycle.
- done  output  1  one-cycle pulse; product valid.
- product  output  32  low 32 bits of a*b; held until the next accepted start.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_ctrl  output  4  ALU control code.
- alu_result  input  32  ALU result, combinational from alu_a/alu_b/alu_ctrl.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset forces:
  - state=IDLE, busy=0, done=0, product=0.
  - internal mcand/mplier/count=0.
  - alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- ALU codes driven:
  - 4'b0010 = add a+b.
  - 4'b0101 = b<<1.
  - 4'b0111 = b>>1 logical.
  - Bit 3 is never set (no subtract used).
  - In IDLE/DONE: alu_ctrl=0000, operands 0.
- Registers:
  - mcand[31:0], mplier[31:0], prod[31:0].
  - count[5:0] = iterations completed.
  - product port = prod.
- States and transitions:
  - IDLE:
    - If start=1: mcand<=a, mplier<=b, prod<=0, count<=0, go ADD.
    - busy=0.
  - ADD:
    - alu_a=prod, alu_b=mcand, alu_ctrl=0010.
    - If mplier[0]: prod<=alu_result; else prod unchanged.
    - Go SHL.
  - SHL:
    - alu_a=0, alu_b=mcand, alu_ctrl=0101.
    - mcand<=alu_result.
    - Go SHR.
  - SHR:
    - alu_a=0, alu_b=mplier, alu_ctrl=0111.
    - mplier<=alu_result; count<=count+1.
    - Go DONE if (count==31), or if (EARLY_EXIT and alu_result==0).
    - Zero detect is the controller's own 32-bit reduction of alu_result, not any ALU zero flag.
    - Otherwise go ADD.
  - DONE:
    - done=1, busy=1 for exactly one cycle.
    - Go IDLE.
- Latency:
  - Accepting edge = edge 0; each iteration is 3 cycles.
  - After n iterations, done is high in cycle 3n+1.
  - Cycles: n=1 -> 4, n=32 -> 97.
  - Next start is accepted in the cycle after DONE at the earliest.
- Arithmetic:
  - Product is modulo 2^32; overflow is silently discarded, no flag.
  - Operands are unsigned.
- Boundary conditions:
  - start while busy (ADD/SHL/SHR/DONE): ignored; no re-latch.
  - start held high continuously: a new operation begins each time IDLE is re-entered.
  - b=0: one iteration (ADD with no update, SHL, SHR), product=0.
  - a=0: iterations continue per b; product=0.
  - rst_n low mid-operation: immediate abort to reset values; no done pulse; product=0.
  - a/b changing after start: no effect on the in-flight operation.

Test Plan:
- Reset then start with a=3, b=5 -> done high in cycle 10 after the start edge; product=15; busy high cycles 1..10.
- a=0x00010000, b=0x00010000, EARLY_EXIT=1 -> product=0x00000000 (overflow dropped); done at cycle 3*17+1=52.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x00000001; done at cycle 97; alu_ctrl sequence 0010,0101,0111 repeated 32 times.
- a=7, b=0 -> done at cycle 4, product=0. Same operands with EARLY_EXIT=0 -> done at cycle 97, product=0.
- Start a=6, b=7, then pulse start with a=2, b=2 at cycle 5 -> second start ignored; product=42. Start a=2, b=2 in the cycle after done -> product=4.
- Start a=9, b=9; assert rst_n=0 at cycle 5 -> busy, done and product go 0 asynchronously; no done pulse. After release, start a=2, b=3 -> product=6.
